// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V core: sequences fetch/decode/execute/
// memory/writeback over a shared ALU and memory port, with a mem_ready handshake.
module multicycle_controller #(
   parameter int CNT_W   = 32,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic               RegWrite,
   output logic               illegal,
   output logic [CNT_W-1:0]   instret,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t state, state_nxt;
   logic   pcupdate, branch;
   logic   irwrite_raw, memwrite_raw, regwrite_raw;
   logic   illegal_nxt, retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         illegal <= 1'b0;
         instret <= '0;
      end else begin
         state   <= state_nxt;
         illegal <= illegal_nxt;
         if (retire) instret <= instret + 1'b1;
      end
   end

   always_comb begin
      state_nxt    = FETCH;
      illegal_nxt  = 1'b0;
      retire       = 1'b0;
      pcupdate     = 1'b0;
      branch       = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      case (state)
         FETCH: begin
            state_nxt   = mem_ready ? DECODE : FETCH;
            ALUSrcB     = 2'b10;
            ResultSrc   = 2'b10;
            irwrite_raw = mem_ready;
            pcupdate    = mem_ready;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_R:         state_nxt = EXECUTER;
               OP_I:         state_nxt = EXECUTEI;
               OP_BEQ:       state_nxt = BEQ;
               OP_JAL:       state_nxt = JAL;
               default: begin
                  state_nxt   = FETCH;
                  illegal_nxt = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            state_nxt = op[5] ? MEMWRITE : MEMREAD;
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
         end
         MEMREAD: begin
            state_nxt = mem_ready ? MEMWB : MEMREAD;
            AdrSrc    = 1'b1;
         end
         MEMWB: begin
            ResultSrc    = 2'b01;
            regwrite_raw = 1'b1;
            retire       = 1'b1;
         end
         MEMWRITE: begin
            // Write enable is held until memory accepts; the store retires on that edge.
            state_nxt    = mem_ready ? FETCH : MEMWRITE;
            AdrSrc       = 1'b1;
            memwrite_raw = 1'b1;
            retire       = mem_ready;
         end
         EXECUTER: begin
            state_nxt = ALUWB;
            ALUSrcA   = 2'b10;
            ALUOp     = 2'b10;
         end
         EXECUTEI: begin
            state_nxt = ALUWB;
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ALUOp     = 2'b10;
         end
         ALUWB: begin
            regwrite_raw = 1'b1;
            retire       = 1'b1;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
            retire  = 1'b1;
         end
         JAL: begin
            state_nxt = ALUWB;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pcupdate  = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Enables are gated by rst_n so nothing writes while reset is held,
   // even though FETCH itself would follow mem_ready.
   assign PCWrite  = rst_n & (pcupdate | (branch & zero));
   assign IRWrite  = rst_n & irwrite_raw;
   assign MemWrite = rst_n & memwrite_raw;
   assign RegWrite = rst_n & regwrite_raw;
   assign state_o  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state sequence and checks outputs, instret, illegal and reset behaviour.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic        zero;
   logic        mem_ready;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [31:0] instret;
   logic [3:0]  state_o;

   int vecs = 0;
   int errs = 0;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   multicycle_controller #(.CNT_W(32), .STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegWrite(RegWrite), .illegal(illegal), .instret(instret), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vecs++; if (state_o !== 4'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state_o); end
      vecs++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin errs++; $display("FAIL reset_enables got PCWrite=%b IRWrite=%b want 0 0", PCWrite, IRWrite); end
      vecs++; if (instret !== 32'd0 || illegal !== 1'b0) begin errs++; $display("FAIL reset_regs got instret=%0d illegal=%b want 0 0", instret, illegal); end
      mem_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_lw;
      logic [3:0] st [6];
      st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         op = LW; mem_ready = (i < 5); #1;
         vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state_o, st[i]); end
         vecs++; if (RegWrite !== (st[i] == 4'd4)) begin errs++; $display("FAIL lw_regwrite[%0d] got %b want %b", i, RegWrite, st[i] == 4'd4); end
         if (i == 0) begin
            vecs++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
               errs++; $display("FAIL lw_fetch got IRWrite=%b PCWrite=%b ALUSrcB=%b ResultSrc=%b want 1 1 10 10", IRWrite, PCWrite, ALUSrcB, ResultSrc); end
         end
         if (i == 3) begin
            vecs++; if (AdrSrc !== 1'b1) begin errs++; $display("FAIL lw_memread_adrsrc got %b want 1", AdrSrc); end
         end
         if (i == 4) begin
            vecs++; if (ResultSrc !== 2'b01) begin errs++; $display("FAIL lw_memwb_resultsrc got %b want 01", ResultSrc); end
         end
      end
      vecs++; if (instret !== 32'd1) begin errs++; $display("FAIL lw_instret got %0d want 1", instret); end
   endtask

   task automatic test_sw;
      logic [3:0] st [8];
      logic       mr [8];
      st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         op = SW; mem_ready = mr[i]; #1;
         vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state_o, st[i]); end
         vecs++; if (MemWrite !== (st[i] == 4'd5)) begin errs++; $display("FAIL sw_memwrite[%0d] got %b want %b", i, MemWrite, st[i] == 4'd5); end
         if (i == 5) begin
            vecs++; if (instret !== 32'd1) begin errs++; $display("FAIL sw_instret_wait got %0d want 1", instret); end
         end
      end
      vecs++; if (instret !== 32'd2) begin errs++; $display("FAIL sw_instret got %0d want 2", instret); end
   endtask

   task automatic test_beq;
      logic [3:0] st [4];
      st = '{4'd0, 4'd1, 4'd9, 4'd0};
      for (int z = 1; z >= 0; z--) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = BQ; zero = z[0]; mem_ready = (i < 3); #1;
            vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL beq_state[z=%0d,%0d] got %0d want %0d", z, i, state_o, st[i]); end
            if (i == 1 || i == 2) begin
               vecs++; if (PCWrite !== (i == 2 && z == 1)) begin errs++; $display("FAIL beq_pcwrite[z=%0d,%0d] got %b want %b", z, i, PCWrite, (i == 2 && z == 1)); end
            end
            if (i == 2) begin
               vecs++; if (ALUOp !== 2'b01 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin
                  errs++; $display("FAIL beq_alu[z=%0d] got ALUOp=%b A=%b B=%b want 01 10 00", z, ALUOp, ALUSrcA, ALUSrcB); end
            end
         end
      end
      zero = 1'b0;
      vecs++; if (instret !== 32'd4) begin errs++; $display("FAIL beq_instret got %0d want 4", instret); end
   endtask

   task automatic test_alu;
      logic [3:0] st [5];
      for (int k = 0; k < 2; k++) begin
         st = '{4'd0, 4'd1, (k == 0) ? 4'd6 : 4'd7, 4'd8, 4'd0};
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = (k == 0) ? RT : IT; mem_ready = (i < 4); #1;
            vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL alu_state[%0d,%0d] got %0d want %0d", k, i, state_o, st[i]); end
            if (i == 2) begin
               vecs++; if (ALUOp !== 2'b10 || ALUSrcA !== 2'b10 || ALUSrcB !== ((k == 0) ? 2'b00 : 2'b01)) begin
                  errs++; $display("FAIL alu_exec[%0d] got ALUOp=%b A=%b B=%b want 10 10 %b", k, ALUOp, ALUSrcA, ALUSrcB, (k == 0) ? 2'b00 : 2'b01); end
            end
            vecs++; if (RegWrite !== (i == 3)) begin errs++; $display("FAIL alu_regwrite[%0d,%0d] got %b want %b", k, i, RegWrite, i == 3); end
         end
      end
      vecs++; if (instret !== 32'd6) begin errs++; $display("FAIL alu_instret got %0d want 6", instret); end
   endtask

   task automatic test_illegal;
      logic [3:0] st [4];
      st = '{4'd0, 4'd1, 4'd0, 4'd0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         op = BAD; mem_ready = (i < 2); #1;
         vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL ill_state[%0d] got %0d want %0d", i, state_o, st[i]); end
         vecs++; if (illegal !== (i == 2)) begin errs++; $display("FAIL ill_pulse[%0d] got %b want %b", i, illegal, i == 2); end
      end
      vecs++; if (instret !== 32'd6) begin errs++; $display("FAIL ill_instret got %0d want 6", instret); end
   endtask

   task automatic test_jal;
      logic [3:0] st [5];
      st = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         op = JL; mem_ready = (i < 4); #1;
         vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL jal_state[%0d] got %0d want %0d", i, state_o, st[i]); end
         if (i >= 1) begin
            vecs++; if (PCWrite !== (i == 2)) begin errs++; $display("FAIL jal_pcwrite[%0d] got %b want %b", i, PCWrite, i == 2); end
         end
         vecs++; if (RegWrite !== (i == 3)) begin errs++; $display("FAIL jal_regwrite[%0d] got %b want %b", i, RegWrite, i == 3); end
         if (i == 2) begin
            vecs++; if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
               errs++; $display("FAIL jal_alu got A=%b B=%b ALUOp=%b want 01 10 00", ALUSrcA, ALUSrcB, ALUOp); end
         end
      end
      vecs++; if (instret !== 32'd7) begin errs++; $display("FAIL jal_instret got %0d want 7", instret); end
   endtask

   task automatic test_reset_mid;
      logic [3:0] st [4];
      st = '{4'd0, 4'd1, 4'd2, 4'd5};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         op = SW; mem_ready = (i < 3); #1;
         vecs++; if (state_o !== st[i]) begin errs++; $display("FAIL rst_pre_state[%0d] got %0d want %0d", i, state_o, st[i]); end
      end
      vecs++; if (MemWrite !== 1'b1) begin errs++; $display("FAIL rst_pre_memwrite got %b want 1", MemWrite); end
      #1 rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      vecs++; if (state_o !== 4'd0) begin errs++; $display("FAIL rst_mid_state got %0d want 0", state_o); end
      vecs++; if (MemWrite !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0) begin
         errs++; $display("FAIL rst_mid_enables got Mem=%b PC=%b IR=%b Reg=%b want 0 0 0 0", MemWrite, PCWrite, IRWrite, RegWrite); end
      vecs++; if (instret !== 32'd0) begin errs++; $display("FAIL rst_mid_instret got %0d want 0", instret); end
      mem_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         vecs++; if (state_o !== 4'd0 || IRWrite !== 1'b0) begin
            errs++; $display("FAIL rst_hold[%0d] got state=%0d IRWrite=%b want 0 0", i, state_o, IRWrite); end
      end
      vecs++; if (instret !== 32'd0) begin errs++; $display("FAIL rst_post_instret got %0d want 0", instret); end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_sw;
      test_beq;
      test_alu;
      test_illegal;
      test_jal;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
